// File: rtl/muldiv_pkg.sv
// Shared types and sizing for the iterative multiply/divide unit.
package muldiv_pkg;
  localparam int WIDTH_DEF = 32;
  localparam int CNT_W     = $clog2(WIDTH_DEF);

  typedef enum logic [1:0] {ST_IDLE, ST_MUL, ST_DIV} state_e;
  typedef enum logic {MODE_MUL, MODE_DIV} mode_e;
endpackage

// File: rtl/muldiv_step.sv
// One combinational iteration: shift-add multiply step or restoring divide step.
module muldiv_step
  import muldiv_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  mode_e              mode,
  input  logic [2*WIDTH:0]   acc_i,
  input  logic [WIDTH-1:0]   opnd_i,
  output logic [2*WIDTH:0]   acc_o
);
  logic [WIDTH:0]   mul_sum;
  logic [WIDTH:0]   rem_sh;
  logic [WIDTH-1:0] rem_new;
  logic [WIDTH-1:0] quo_sh;

  always_comb begin
    mul_sum = acc_i[2*WIDTH:WIDTH];
    if (acc_i[0]) mul_sum = acc_i[2*WIDTH:WIDTH] + {1'b0, opnd_i};

    // remainder keeps its top bit during the shift so the compare never overflows
    rem_sh  = {acc_i[2*WIDTH-1:WIDTH], acc_i[WIDTH-1]};
    quo_sh  = {acc_i[WIDTH-2:0], 1'b0};
    rem_new = rem_sh[WIDTH-1:0];
    if (rem_sh >= {1'b0, opnd_i}) begin
      rem_new   = WIDTH'(rem_sh - {1'b0, opnd_i});
      quo_sh[0] = 1'b1;
    end

    if (mode == MODE_MUL) acc_o = {1'b0, mul_sum, acc_i[WIDTH-1:1]};
    else                  acc_o = {1'b0, rem_new, quo_sh};
  end
endmodule

// File: rtl/muldiv_ctrl.sv
// Multiply/divide sequencer: FSM, iteration counter, operand latch, HI/LO and stall.
//   state   | meaning
//   ST_IDLE | no operation; accepts start_mul/start_div unless flushed
//   ST_MUL  | MULTU iterating, acc holds {carry, upper, lower} product
//   ST_DIV  | DIVU iterating, acc holds {0, remainder, quotient}
module muldiv_ctrl
  import muldiv_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_mul,
  input  logic             start_div,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic             rd_hi,
  input  logic             rd_lo,
  input  logic             flush,
  output logic             busy,
  output logic             stall,
  output logic             done,
  output logic             div_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);
  localparam int CW = $clog2(WIDTH);

  state_e           state_q, state_d;
  logic [CW-1:0]    count_q, count_d;
  logic [2*WIDTH:0] acc_q, acc_d, acc_nxt;
  logic [WIDTH-1:0] opnd_q, opnd_d;
  logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d;
  logic             done_q, done_d, dz_q, dz_d;
  mode_e            mode;

  assign mode = (state_q == ST_DIV) ? MODE_DIV : MODE_MUL;

  muldiv_step #(.WIDTH(WIDTH)) u_step (
    .mode   (mode),
    .acc_i  (acc_q),
    .opnd_i (opnd_q),
    .acc_o  (acc_nxt)
  );

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    acc_d   = acc_q;
    opnd_d  = opnd_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    dz_d    = dz_q;
    done_d  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (!flush) begin
          if (start_mul) begin
            state_d = ST_MUL;
            count_d = '0;
            opnd_d  = op_a;
            acc_d   = {1'b0, {WIDTH{1'b0}}, op_b};
          end else if (start_div) begin
            state_d = ST_DIV;
            count_d = '0;
            opnd_d  = op_b;
            acc_d   = {1'b0, {WIDTH{1'b0}}, op_a};
          end
        end
      end
      ST_MUL, ST_DIV: begin
        if (flush) begin
          state_d = ST_IDLE;
        end else begin
          acc_d   = acc_nxt;
          count_d = count_q + CW'(1);
          if (count_q == CW'(WIDTH - 1)) begin
            state_d = ST_IDLE;
            hi_d    = acc_nxt[2*WIDTH-1:WIDTH];
            lo_d    = acc_nxt[WIDTH-1:0];
            dz_d    = (state_q == ST_DIV) && (opnd_q == '0);
            done_d  = 1'b1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      count_q <= '0;
      acc_q   <= '0;
      opnd_q  <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      done_q  <= 1'b0;
      dz_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      acc_q   <= acc_d;
      opnd_q  <= opnd_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      done_q  <= done_d;
      dz_q    <= dz_d;
    end
  end

  assign busy     = (state_q != ST_IDLE);
  assign stall    = busy & (rd_hi | rd_lo | start_mul | start_div);
  assign done     = done_q;
  assign div_zero = dz_q;
  assign hi       = hi_q;
  assign lo       = lo_q;
endmodule

// File: tb/tb_muldiv_ctrl.sv
// Randomized and directed bench for muldiv_ctrl against an arithmetic reference.
module tb_muldiv_ctrl;
  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start_mul = 1'b0, start_div = 1'b0;
  logic [W-1:0] op_a = '0, op_b = '0;
  logic         rd_hi = 1'b0, rd_lo = 1'b0, flush = 1'b0;
  logic         busy, stall, done, div_zero;
  logic [W-1:0] hi, lo;

  int checks = 0;
  int failures = 0;

  muldiv_ctrl #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .start_mul(start_mul), .start_div(start_div),
    .op_a(op_a), .op_b(op_b), .rd_hi(rd_hi), .rd_lo(rd_lo), .flush(flush),
    .busy(busy), .stall(stall), .done(done), .div_zero(div_zero), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // {hi, lo} that MULTU/DIVU must produce
  function automatic logic [63:0] ref_op(input bit is_mul, input logic [W-1:0] a, input logic [W-1:0] b);
    if (is_mul)  return 64'(a) * 64'(b);
    if (b == 0)  return {a, 32'hFFFF_FFFF};
    return {a % b, a / b};
  endfunction

  // call at a negedge with the unit idle
  task automatic run_op(input string tag, input bit is_mul, input logic [W-1:0] a, input logic [W-1:0] b);
    logic [63:0] e;
    int n, dn;
    e = ref_op(is_mul, a, b);
    n = 0; dn = 0;
    start_mul = is_mul; start_div = !is_mul; op_a = a; op_b = b;
    @(negedge clk);
    start_mul = 0; start_div = 0;
    while (busy && n < 40) begin
      n++;
      if (done) dn++;
      @(negedge clk);
    end
    chk({tag, "_busy_cycles"}, n, 32);
    chk({tag, "_early_done"}, dn, 0);
    chk({tag, "_done"}, done, 1);
    chk({tag, "_hilo"}, {hi, lo}, e);
    chk({tag, "_div_zero"}, div_zero, (!is_mul && b == 0));
    @(negedge clk);
    chk({tag, "_done_pulse"}, done, 0);
  endtask

  initial begin
    logic [W-1:0] a, b, a2, b2;
    logic [63:0]  prev;
    int n, sc, bad;
    bit m;

    #12;
    chk("rst_hi", hi, 0);
    chk("rst_lo", lo, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_div_zero", div_zero, 0);
    @(negedge clk); rst_n = 1;
    @(negedge clk);

    run_op("mul_ff", 1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    run_op("div_100_7", 0, 100, 7);
    run_op("div_5_0", 0, 5, 0);

    for (int i = 0; i < 12; i++) begin
      m = 1'($urandom_range(0, 1));
      a = $urandom;
      case ($urandom_range(0, 3))
        0:       b = 0;
        1:       b = $urandom_range(1, 20);
        default: b = $urandom;
      endcase
      run_op($sformatf("rand%0d", i), m, a, b);
    end

    // MFLO waiting on MULTU 3 x 4
    start_mul = 1; op_a = 3; op_b = 4;
    @(negedge clk);
    start_mul = 0; rd_lo = 1;
    #1;
    n = 0; sc = 0;
    while (busy && n < 40) begin
      n++;
      if (stall) sc++;
      @(negedge clk); #1;
    end
    chk("mflo_busy_cycles", n, 32);
    chk("mflo_stall_cycles", sc, 32);
    chk("mflo_stall_done", stall, 0);
    chk("mflo_done", done, 1);
    chk("mflo_lo", lo, 12);
    rd_lo = 0;
    @(negedge clk);

    // start_mul held through the whole first operation
    prev = ref_op(1, 3, 4);
    a = $urandom; b = $urandom; a2 = $urandom; b2 = $urandom;
    start_mul = 1; op_a = a; op_b = b;
    @(negedge clk);
    op_a = a2; op_b = b2;
    n = 0; sc = 0; bad = 0;
    while (busy && n < 40) begin
      n++;
      if (stall) sc++;
      if ({hi, lo} !== prev) bad++;
      @(negedge clk);
    end
    chk("b2b_busy_cycles", n, 32);
    chk("b2b_stall_cycles", sc, 32);
    chk("b2b_early_write", bad, 0);
    chk("b2b_first_hilo", {hi, lo}, ref_op(1, a, b));
    chk("b2b_gap_idle", busy, 0);
    @(negedge clk);
    start_mul = 0;
    chk("b2b_second_accepted", busy, 1);
    n = 0;
    while (busy && n < 40) begin n++; @(negedge clk); end
    chk("b2b_second_cycles", n, 32);
    chk("b2b_second_hilo", {hi, lo}, ref_op(1, a2, b2));
    @(negedge clk);

    // flush at cycle 10 of a DIVU with HI/LO preset to 0xA/0xB
    run_op("pre_flush", 0, 32'hBA, 32'h10);
    start_div = 1; op_a = $urandom; op_b = $urandom_range(1, 1000);
    @(negedge clk);
    start_div = 0;
    repeat (9) @(negedge clk);
    flush = 1;
    @(negedge clk);
    flush = 0;
    chk("flush_idle", busy, 0);
    chk("flush_no_done", done, 0);
    chk("flush_hilo", {hi, lo}, 64'h0000000A_0000000B);
    @(negedge clk);
    chk("flush_no_done_late", done, 0);

    flush = 1; start_mul = 1; op_a = 9; op_b = 9;
    @(negedge clk);
    chk("flush_blocks_start", busy, 0);
    flush = 0; start_mul = 0;
    @(negedge clk);
    chk("flush_blocks_hilo", {hi, lo}, 64'h0000000A_0000000B);

    // asynchronous reset in the middle of a MULTU
    start_mul = 1; op_a = $urandom; op_b = $urandom;
    @(negedge clk);
    start_mul = 0;
    repeat (14) @(negedge clk);
    #2 rst_n = 0;
    #1;
    chk("arst_busy", busy, 0);
    chk("arst_hilo", {hi, lo}, 0);
    chk("arst_done", done, 0);
    @(negedge clk); rst_n = 1;
    @(negedge clk);
    run_op("mul_6_7", 1, 6, 7);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
